imem_port_arbiter: RTL and testbench

//  Owns the single-port synchronous instruction SRAM and shares it between the

---
 rtl/cpu_pkg.sv | 13 +
 rtl/imem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IMEM arbiter state encoding.
package cpu_pkg;

    localparam int unsigned INST_ADDR_WIDTH = 10;
    localparam int unsigned INST_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } imem_arb_state_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// Single-port IMEM owner: arbitrates loader writes against IF fetches across LOAD/RUN/HALT.
// Optional IMEM_WR_PROTECT_EN refuses loader writes in RUN and adds the ld_err output.
module imem_port_arbiter #(
    parameter int unsigned INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
    parameter int unsigned INST_DATA_WIDTH = cpu_pkg::INST_DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [INST_ADDR_WIDTH-1:0] ld_addr,
    input  logic [INST_DATA_WIDTH-1:0] ld_wdata,
    input  logic                       ld_done,
`ifdef IMEM_WR_PROTECT_EN
    output logic                       ld_err,
`endif
    input  logic                       fetch_req,
    input  logic [INST_ADDR_WIDTH-1:0] fetch_addr,
    output logic                       fetch_gnt,
    output logic                       fetch_rvalid,
    output logic [INST_DATA_WIDTH-1:0] fetch_rdata,
    input  logic                       halt_req,
    input  logic                       resume_req,
    output logic                       cpu_start,
    output logic [1:0]                 arb_state,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    output logic [INST_DATA_WIDTH-1:0] mem_wdata,
    input  logic [INST_DATA_WIDTH-1:0] mem_rdata
);
    import cpu_pkg::*;

    imem_arb_state_e state_q, state_d;
    logic            fetch_rvalid_q, fetch_rvalid_d;
    logic            ld_gnt;

`ifndef IMEM_WR_PROTECT_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`endif

    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        fetch_gnt = 1'b0;
        cpu_start = 1'b0;
`ifdef IMEM_WR_PROTECT_EN
        ld_err    = 1'b0;
`endif
        case (state_q)
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_done) state_d = RUN;
            end
            RUN: begin
                cpu_start = 1'b1;
`ifdef IMEM_WR_PROTECT_EN
                fetch_gnt = fetch_req;
                ld_err    = ld_valid;
`else
                // a starved loader steals exactly one cycle from the fetch path
                fetch_gnt = fetch_req && !(starved && ld_valid);
                ld_ready  = !fetch_req || starved;
`endif
                if (halt_req) state_d = HALT;
            end
            HALT: begin
                ld_ready = 1'b1;
                if (resume_req && !halt_req) state_d = RUN;
            end
            default: state_d = LOAD;
        endcase
    end

    assign ld_gnt = ld_valid && ld_ready;

`ifndef IMEM_WR_PROTECT_EN
    always_comb begin
        starve_cnt_d = '0;
        if (state_q == RUN && ld_valid && fetch_gnt)
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt_q <= '0;
        else      starve_cnt_q <= starve_cnt_d;
    end
`endif

    // SRAM port is held idle while reset is asserted
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            mem_en = 1'b0;
        end else if (fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
        end else if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign fetch_rvalid_d = fetch_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= LOAD;
            fetch_rvalid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_rvalid_q <= fetch_rvalid_d;
        end
    end

    assign fetch_rvalid = fetch_rvalid_q;
    assign fetch_rdata  = mem_rdata;
    assign arb_state    = state_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: SRAM environment, cycle model with image scoreboard, directed vectors.
module tb_imem_port_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0, rst = 1'b0;
    logic          ld_valid = 1'b0, ld_done = 1'b0, fetch_req = 1'b0;
    logic          halt_req = 1'b0, resume_req = 1'b0;
    logic [AW-1:0] ld_addr = '0, fetch_addr = '0;
    logic [DW-1:0] ld_wdata = '0, mem_rdata = '0;
    logic          ld_ready, fetch_gnt, fetch_rvalid, cpu_start, mem_en, mem_we;
    logic [1:0]    arb_state;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, fetch_rdata;
`ifdef IMEM_WR_PROTECT_EN
    logic          ld_err;
`endif

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    imem_port_arbiter #(.INST_ADDR_WIDTH(AW), .INST_DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_done(ld_done),
`ifdef IMEM_WR_PROTECT_EN
        .ld_err(ld_err),
`endif
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .halt_req(halt_req), .resume_req(resume_req), .cpu_start(cpu_start),
        .arb_state(arb_state), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM macro stand-in and the model's view of its contents
    logic [DW-1:0] sram  [0:(1<<AW)-1];
    logic [DW-1:0] image [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) begin sram[i] = '0; image[i] = '0; end

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0=load 1=run 2=halt; waits = consecutive fetch wins while loader is pending
    int            m_mode = 0, m_waits = 0, n_mode, n_waits;
    bit            m_pend = 0, n_pend, n_write;
    logic [DW-1:0] m_pdata = '0, n_pdata, n_wdata;
    logic [AW-1:0] n_waddr;

    always @(negedge clk) begin
        bit e_ldr, e_gnt, e_start, wr;
        if (!rst) begin
            chk("rst_state", arb_state, 0);
            chk("rst_start", cpu_start, 0);
            chk("rst_rvalid", fetch_rvalid, 0);
            chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
            n_mode = 0; n_waits = 0; n_pend = 0; n_write = 0; n_pdata = '0;
        end else begin
            e_ldr = 1; e_gnt = 0; e_start = 0; wr = 0; n_mode = m_mode;
            case (m_mode)
                0: begin wr = ld_valid; if (ld_done) n_mode = 1; end
                1: begin
                    e_start = 1;
`ifdef IMEM_WR_PROTECT_EN
                    e_ldr = 0; e_gnt = fetch_req;
                    chk("ld_err", ld_err, ld_valid);
`else
                    e_gnt = fetch_req && !(ld_valid && m_waits >= LIM);
                    e_ldr = !fetch_req || m_waits >= LIM;
                    wr    = ld_valid && e_ldr;
`endif
                    if (halt_req) n_mode = 2;
                end
                default: begin wr = ld_valid; if (resume_req && !halt_req) n_mode = 1; end
            endcase
            chk("state", arb_state, m_mode);
            chk("cpu_start", cpu_start, e_start);
            chk("ld_ready", ld_ready, e_ldr);
            chk("fetch_gnt", fetch_gnt, e_gnt);
            chk("mem_en", mem_en, wr || e_gnt);
            chk("mem_we", mem_we, wr);
            if (wr) chk("mem_wr", {mem_addr, mem_wdata}, {ld_addr, ld_wdata});
            if (e_gnt) chk("mem_raddr", mem_addr, fetch_addr);
            chk("rvalid", fetch_rvalid, m_pend);
            if (m_pend) chk("rdata", fetch_rdata, m_pdata);
            n_waits = (m_mode == 1 && e_gnt && ld_valid) ? m_waits + 1 : 0;
            n_pend  = e_gnt;
            n_pdata = image[fetch_addr];
            n_write = wr; n_waddr = ld_addr; n_wdata = ld_wdata;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode <= 0; m_waits <= 0; m_pend <= 0;
        end else begin
            m_mode <= n_mode; m_waits <= n_waits; m_pend <= n_pend; m_pdata <= n_pdata;
            if (n_write) image[n_waddr] <= n_wdata;
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic mid();  @(negedge clk);    endtask

    initial begin
        int found;
        logic [DW-1:0] exp3;
        step(); step();
        mid(); chk("t0_state", arb_state, 0); chk("t0_mem_en", mem_en, 0);
        step(); rst = 1'b1;

        // boot image: word i = A5000000 | i
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1; ld_addr = AW'(i); ld_wdata = 32'hA500_0000 | i; ld_done = (i == 15);
            mid(); chk("t1_we", mem_we, 1);
            step();
        end
        ld_valid = 1'b0; ld_done = 1'b0;
        mid(); chk("t1_start", cpu_start, 1); chk("t1_state", arb_state, 1);

        step(); fetch_req = 1'b1; fetch_addr = 5;
        mid(); chk("t2_gnt", fetch_gnt, 1);
        step(); fetch_req = 1'b0;
        mid(); chk("t2_rvalid", fetch_rvalid, 1); chk("t2_rdata", fetch_rdata, 32'hA500_0005);

        // waits counter must clear when the loader backs off
        step(); ld_valid = 1'b1; ld_addr = 40; ld_wdata = 32'h55; fetch_req = 1'b1; fetch_addr = 30;
        step(); step(); ld_valid = 1'b0;
        step(); ld_valid = 1'b1;
        step(); step(); step(); ld_valid = 1'b0; fetch_req = 1'b0;
        step();

        step(); ld_valid = 1'b1; ld_addr = 3; ld_wdata = 32'h1234_5678; fetch_req = 1'b1; fetch_addr = 20;
`ifdef IMEM_WR_PROTECT_EN
        mid(); chk("t6_ready", ld_ready, 0); chk("t6_err", ld_err, 1); chk("t6_we", mem_we, 0);
        step(); ld_valid = 1'b0; exp3 = 32'hA500_0003;
`else
        found = 0;
        for (int c = 1; c <= 10; c++) begin
            mid();
            if (!fetch_gnt) begin found = c; break; end
            step(); fetch_addr = fetch_addr + 1'b1;
        end
        chk("t3_steal_cycle", found, 5); chk("t3_steal_we", mem_we, 1);
        step(); ld_valid = 1'b0; exp3 = 32'h1234_5678;
`endif
        fetch_addr = 3;
        mid(); chk("t3_gnt_after", fetch_gnt, 1);
        step(); fetch_req = 1'b0;
        mid(); chk("t3_rdata", fetch_rdata, exp3);

        step(); halt_req = 1'b1; fetch_req = 1'b1; fetch_addr = 7;
        step(); halt_req = 1'b0; ld_valid = 1'b1; ld_addr = 9; ld_wdata = 32'hDEAD_BEEF;
        mid(); chk("t4_start", cpu_start, 0); chk("t4_state", arb_state, 2);
        chk("t4_rvalid", fetch_rvalid, 1); chk("t4_rdata", fetch_rdata, 32'hA500_0007);
        chk("t4_we", mem_we, 1); chk("t4_gnt", fetch_gnt, 0);
        step(); ld_valid = 1'b0; fetch_req = 1'b0; halt_req = 1'b1; resume_req = 1'b1;
        mid(); chk("t4_hold", arb_state, 2);
        step(); halt_req = 1'b0;
        mid(); chk("t4_still", arb_state, 2);
        step(); resume_req = 1'b0;
        mid(); chk("t4_resume", cpu_start, 1);
        step(); fetch_req = 1'b1; fetch_addr = 9;
        step(); fetch_req = 1'b0;
        mid(); chk("t4_rdata", fetch_rdata, 32'hDEAD_BEEF);

        step(); fetch_req = 1'b1; fetch_addr = 2;
        step(); rst = 1'b0; #1;
        chk("t5_state", arb_state, 0); chk("t5_rvalid", fetch_rvalid, 0);
        chk("t5_start", cpu_start, 0); chk("t5_mem_en", mem_en, 0);
        fetch_req = 1'b0;
        step(); step(); rst = 1'b1;
        ld_valid = 1'b1; ld_addr = 1; ld_wdata = 32'h77; ld_done = 1'b1;
        step(); ld_valid = 1'b0; ld_done = 1'b0; fetch_req = 1'b1; fetch_addr = 1;
        step(); fetch_req = 1'b0;
        mid(); chk("t5_reload", fetch_rdata, 32'h77);
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
